nf_ahb_arb: RTL and testbench

AHB-Lite master-side arbiter that shares the single AHB master port of the interconnect between `master_c` internal requesters, such as instruction fetch and load/store. It sits directly in front of the AHB router and owns its master-side inputs (`haddr`, `hwrite`, `htrans`, `hwdata`). It consumes the router's `hrdata`/`hready`/`hresp` responses. Arbitration is round-robin with one outstanding transfer at a time, sequenced by an IDLE/ADDR/DATA state machine.

---
 rtl/nf_ahb_arb.sv | 141 ++++++++++++++
 tb/tb_nf_ahb_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_ahb_arb.sv
// nf_ahb_arb: round-robin arbiter sharing one AHB-Lite master port among master_c requesters.
// Latency: m_gnt 1 cycle after m_req, m_done 2 cycles after m_gnt plus one per hready=0 cycle.
// Backpressure: hready=0 holds ADDR/DATA; NF_AHB_ARB_TIMEOUT_EN adds a forced-completion timeout.
module nf_ahb_arb #(
    parameter int master_c  = 2,
    parameter int timeout_c = 255
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic [master_c-1:0]        m_req,
    input  logic [master_c-1:0][31:0]  m_addr,
    input  logic [master_c-1:0]        m_write,
    input  logic [master_c-1:0][31:0]  m_wdata,
    output logic [master_c-1:0]        m_gnt,
    output logic [master_c-1:0]        m_done,
    output logic [31:0]                m_rdata,
    output logic                       m_err,
    output logic [31:0]                haddr,
    output logic                       hwrite,
    output logic [1:0]                 htrans,
    output logic [31:0]                hwdata,
    input  logic [31:0]                hrdata,
    input  logic                       hready,
    input  logic                       hresp
);
    localparam int IDX_W = (master_c > 1) ? $clog2(master_c) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] own_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             to_hit;
    logic [31:0]      own_wdata;
    int               cand;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= master_c; i++) begin
            cand = (int'(last) + i) % master_c;
            if (!win_vld && m_req[IDX_W'(cand)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(cand);
            end
        end
    end

`ifdef NF_AHB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_c + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE && win_vld) begin
            to_cnt <= '0;
        end else if (state == ST_DATA && !hready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the stalled edge that brings the counter up to timeout_c.
    assign to_hit = (state == ST_DATA) && !hready && (to_cnt == CNT_W'(timeout_c - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_vld)           state_nxt = ST_ADDR;
            ST_ADDR: if (hready)            state_nxt = ST_DATA;
            ST_DATA: if (hready || to_hit)  state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            last      <= IDX_W'(master_c - 1);
            own_idx   <= '0;
            own_wdata <= '0;
            m_gnt     <= '0;
            m_done    <= '0;
            m_rdata   <= '0;
            m_err     <= 1'b0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hwdata    <= '0;
        end else begin
            m_gnt  <= '0;
            m_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        own_idx        <= win_idx;
                        own_wdata      <= m_wdata[win_idx];
                        haddr          <= m_addr[win_idx];
                        hwrite         <= m_write[win_idx];
                        htrans         <= HTRANS_NONSEQ;
                        last           <= win_idx;
                        m_gnt[win_idx] <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        hwdata <= own_wdata;
                    end
                end
                ST_DATA: begin
                    // A real hready completion wins over a coincident timeout.
                    if (hready) begin
                        m_rdata         <= hwrite ? 32'h0 : hrdata;
                        m_err           <= hresp;
                        m_done[own_idx] <= 1'b1;
                    end else if (to_hit) begin
                        m_rdata         <= 32'h0;
                        m_err           <= 1'b1;
                        m_done[own_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nf_ahb_arb.sv
`timescale 1ns/1ps
// Bench for nf_ahb_arb: directed cycle checks plus a completion scoreboard.
module tb_nf_ahb_arb;
    localparam int MC = 2;

    logic                hclk = 1'b0;
    logic                hresetn;
    logic [MC-1:0]       m_req;
    logic [MC-1:0][31:0] m_addr;
    logic [MC-1:0]       m_write;
    logic [MC-1:0][31:0] m_wdata;
    logic [MC-1:0]       m_gnt;
    logic [MC-1:0]       m_done;
    logic [31:0]         m_rdata;
    logic                m_err;
    logic [31:0]         haddr;
    logic                hwrite;
    logic [1:0]          htrans;
    logic [31:0]         hwdata;
    logic [31:0]         hrdata;
    logic                hready;
    logic                hresp;

    nf_ahb_arb #(.master_c(MC), .timeout_c(4)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m_req(m_req), .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
        .haddr(haddr), .hwrite(hwrite), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge hclk);
    endtask

    task automatic push(input int idx, input logic [31:0] rd, input logic er);
        exp_t e;
        e.idx   = 2'(idx);
        e.rdata = rd;
        e.err   = er;
        sb_q.push_back(e);
    endtask

    // Completion monitor: every m_done must match the oldest expected completion.
    always @(negedge hclk) begin : mon
        exp_t e;
        if (m_done != '0) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 32'(m_done), 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("done_idx",      32'(m_done), 32'(1) << e.idx);
                chk("done_rdata",    m_rdata, e.rdata);
                chk("done_err",      32'(m_err), 32'(e.err));
                chk("gnt_done_excl", 32'(m_gnt), 32'h0);
            end
        end
        if (m_gnt != '0) chk("gnt_onehot", 32'($onehot(m_gnt)), 32'h1);
    end

    initial begin
        int n_done;
        hresetn = 1'b0;
        m_req   = '0;
        m_addr  = '0;
        m_write = '0;
        m_wdata = '0;
        hrdata  = 32'h0;
        hready  = 1'b1;
        hresp   = 1'b0;
        repeat (3) tick();
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr",  haddr, 32'h0);
        chk("rst_hwrite", 32'(hwrite), 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_gnt",    32'(m_gnt), 32'h0);
        chk("rst_done",   32'(m_done), 32'h0);
        chk("rst_rdata",  m_rdata, 32'h0);
        chk("rst_err",    32'(m_err), 32'h0);
        hresetn = 1'b1;
        tick();

        // Single read, minimum latency
        m_addr[0] = 32'h0000_1000;
        hrdata    = 32'hDEAD_BEEF;
        m_req     = 2'b01;
        push(0, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("rd_htrans_c1", 32'(htrans), 32'h2);
        chk("rd_haddr_c1",  haddr, 32'h1000);
        chk("rd_gnt_c1",    32'(m_gnt), 32'h1);
        tick();
        chk("rd_htrans_c2", 32'(htrans), 32'h0);
        chk("rd_haddr_c2",  haddr, 32'h1000);
        chk("rd_done_c2",   32'(m_done), 32'h0);
        tick();
        chk("rd_done_c3", 32'(m_done), 32'h1);
        m_req = 2'b00;
        tick();
        chk("rd_idle_gnt",    32'(m_gnt), 32'h0);
        chk("rd_idle_htrans", 32'(htrans), 32'h0);

        // Write from master 1 with three wait states
        m_addr[1]  = 32'h0000_2000;
        m_wdata[1] = 32'h1234_5678;
        m_write    = 2'b10;
        hrdata     = 32'hAAAA_5555;
        m_req      = 2'b10;
        push(1, 32'h0, 1'b0);
        tick();
        chk("wr_htrans", 32'(htrans), 32'h2);
        chk("wr_haddr",  haddr, 32'h2000);
        chk("wr_hwrite", 32'(hwrite), 32'h1);
        chk("wr_gnt",    32'(m_gnt), 32'h2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("wr_hwdata", hwdata, 32'h1234_5678);
            chk("wr_htrans_data", 32'(htrans), 32'h0);
            chk("wr_wait_done", 32'(m_done), 32'h0);
            hready = (k == 3);
        end
        tick();
        chk("wr_done", 32'(m_done), 32'h2);
        m_req   = 2'b00;
        m_write = 2'b00;

        // Contention from reset: grants alternate 0,1,0,1
        hresetn = 1'b0;
        tick();
        hresetn   = 1'b1;
        m_addr[0] = 32'h0000_3000;
        m_addr[1] = 32'h0000_4000;
        hrdata    = 32'hC0DE_0000;
        m_req     = 2'b11;
        for (int t = 0; t < 4; t++) push(t % 2, 32'hC0DE_0000 + 32'(2 + 3 * t), 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c % 3 == 1) begin
                chk("ct_gnt",   32'(m_gnt), 32'(1) << (((c - 1) / 3) % 2));
                chk("ct_haddr", haddr, (((c - 1) / 3) % 2 == 1) ? 32'h4000 : 32'h3000);
            end else begin
                chk("ct_nogrant", 32'(m_gnt), 32'h0);
            end
            hrdata = 32'hC0DE_0000 + 32'(c);
            if (c == 12) m_req = 2'b00;
        end

        // Error: first hresp cycle with hready=0, second with hready=1
        tick();
        m_addr[0] = 32'h0000_5000;
        m_req     = 2'b01;
        push(0, 32'hBAD0_BAD0, 1'b1);
        tick();
        chk("er_gnt", 32'(m_gnt), 32'h1);
        tick();
        hready = 1'b0;
        hresp  = 1'b1;
        tick();
        chk("er_wait", 32'(m_done), 32'h0);
        hready = 1'b1;
        hrdata = 32'hBAD0_BAD0;
        tick();
        chk("er_done", 32'(m_done), 32'h1);
        chk("er_err",  32'(m_err), 32'h1);
        m_req = 2'b00;
        hresp = 1'b0;

        // Reset during DATA abandons the transfer and restores master 0 priority
        tick();
        m_addr[0] = 32'h0000_6000;
        m_addr[1] = 32'h0000_7000;
        hrdata    = 32'h600D_600D;
        m_req     = 2'b01;
        tick();
        chk("rs_gnt", 32'(m_gnt), 32'h1);
        tick();
        hready  = 1'b0;
        hresetn = 1'b0;
        tick();
        chk("rs_htrans", 32'(htrans), 32'h0);
        chk("rs_haddr",  haddr, 32'h0);
        chk("rs_hwrite", 32'(hwrite), 32'h0);
        chk("rs_hwdata", hwdata, 32'h0);
        chk("rs_gnt0",   32'(m_gnt), 32'h0);
        chk("rs_done",   32'(m_done), 32'h0);
        chk("rs_rdata",  m_rdata, 32'h0);
        chk("rs_err",    32'(m_err), 32'h0);
        hresetn = 1'b1;
        hready  = 1'b1;
        m_req   = 2'b11;
        push(0, 32'h600D_600D, 1'b0);
        push(1, 32'h600D_600D, 1'b0);
        tick();
        chk("rs_next_gnt",   32'(m_gnt), 32'h1);
        chk("rs_next_haddr", haddr, 32'h6000);
        for (int c = 5; c <= 9; c++) begin
            tick();
            if (c == 6) m_req = 2'b10;
            if (c == 7) chk("rs_gnt1", 32'(m_gnt), 32'h2);
            if (c == 9) begin
                chk("rs_done1", 32'(m_done), 32'h2);
                m_req = 2'b00;
            end
        end

        // Stalled bus: forced completion with timeout, endless wait without
        tick();
        m_addr[0] = 32'h0000_8000;
        hrdata    = 32'hFFFF_FFFF;
        m_req     = 2'b01;
`ifdef NF_AHB_ARB_TIMEOUT_EN
        push(0, 32'h0, 1'b1);
        tick();
        chk("to_gnt", 32'(m_gnt), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            hready = 1'b0;
            chk("to_wait", 32'(m_done), 32'h0);
        end
        tick();
        chk("to_done", 32'(m_done), 32'h1);
        m_req  = 2'b00;
        hready = 1'b1;
`else
        tick();
        chk("to_gnt", 32'(m_gnt), 32'h1);
        n_done = 0;
        repeat (1000) begin
            tick();
            hready = 1'b0;
            if (m_done != '0) n_done++;
        end
        chk("no_timeout", 32'(n_done), 32'h0);
        hresetn = 1'b0;
        m_req   = 2'b00;
        hready  = 1'b1;
        tick();
        hresetn = 1'b1;
`endif
        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
